// File: rtl/iter_seq_ctrl.sv
// iter_seq_ctrl: IDLE/ITER/HOLD sequencer driving the enable strobes of an iterative datapath.
// Optional abort input and behaviour are enabled by defining SEQ_ABORT_EN.
module iter_seq_ctrl #(
    parameter int ITERS = 28,
    parameter int CW    = $clog2(ITERS) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    output logic          ld_en,
    output logic          it_en,
    output logic          out_en,
    output logic [CW-1:0] iter_cnt,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready
`ifdef SEQ_ABORT_EN
    ,
    input  logic          abort
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          abort_s;
    logic          accept_s;
    logic          last_s;

`ifdef SEQ_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign accept_s = (state_r == IDLE) && req_valid;
    assign last_s   = (cnt_r == LAST_CNT);
    assign iter_cnt = cnt_r;

    // State register and iteration counter; abort outranks completion and res_ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (accept_s) begin
                        state_r <= ITER;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ITER: begin
                    if (abort_s) begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else if (last_s) begin
                        state_r <= HOLD;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= ITER;
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                HOLD: begin
                    cnt_r <= CNT_ZERO;
                    if (abort_s || res_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Strobe and status decode from state plus current inputs (ld_en is Mealy on accept).
    always_comb begin
        req_ready = 1'b0;
        ld_en     = 1'b0;
        it_en     = 1'b0;
        out_en    = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
                ld_en     = accept_s;
            end
            ITER: begin
                busy   = 1'b1;
                it_en  = !abort_s;
                out_en = last_s && !abort_s;
            end
            HOLD: begin
                busy      = 1'b1;
                res_valid = !abort_s;
            end
            default: begin
                req_ready = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_iter_seq_ctrl.sv
// Self-checking bench for iter_seq_ctrl: constant vector table, hand-written reset/abort
// sequences, and randomized traffic against a latency-based reference model.
module tb_iter_seq_ctrl;

    localparam int ITERS = 28;
    localparam int CW    = $clog2(ITERS) + 1;

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          ld_en;
    logic          it_en;
    logic          out_en;
    logic [CW-1:0] iter_cnt;
    logic          busy;
    logic          res_valid;
    logic          res_ready;
`ifdef SEQ_ABORT_EN
    logic          abort_drv;
`endif

    iter_seq_ctrl #(.ITERS(ITERS)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .ld_en     (ld_en),
        .it_en     (it_en),
        .out_en    (out_en),
        .iter_cnt  (iter_cnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready)
`ifdef SEQ_ABORT_EN
        ,
        .abort     (abort_drv)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic          rdy;
        logic          ld;
        logic          it;
        logic          oe;
        logic          bsy;
        logic          rv;
        logic [CW-1:0] cnt;
    } obs_t;

    typedef struct {
        bit rv;
        bit rr;
        int reps;
        bit e_rdy;
        bit e_ld;
        bit e_it;
        bit e_oe;
        bit e_bsy;
        bit e_resv;
        int cnt0;
        int cnt_step;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: age of the current operation in cycles since its accept edge.
    // -1 = no operation, 0..ITERS-1 = iterating, ITERS = result waiting for the consumer.
    int age = -1;

    function automatic obs_t model_exp(input bit rv, input bit ab);
        obs_t e;
        bit   iterating;
        iterating = (age >= 0) && (age < ITERS);
        e.rdy = (age < 0);
        e.ld  = (age < 0) && rv;
        e.it  = iterating && !ab;
        e.oe  = (age == ITERS - 1) && !ab;
        e.bsy = (age >= 0);
        e.rv  = (age == ITERS) && !ab;
        e.cnt = iterating ? CW'(age) : CW'(0);
        return e;
    endfunction

    function automatic void model_update(input bit rv, input bit rr, input bit ab);
        if (age < 0) begin
            if (rv) age = 0;
        end else if (ab) begin
            age = -1;
        end else if (age < ITERS) begin
            age = age + 1;
        end else if (rr) begin
            age = -1;
        end
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = '{req_ready, ld_en, it_en, out_en, busy, res_valid, iter_cnt};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got rdy=%b ld=%b it=%b out=%b busy=%b resv=%b cnt=%0d, expected rdy=%b ld=%b it=%b out=%b busy=%b resv=%b cnt=%0d",
                     name, $time, act.rdy, act.ld, act.it, act.oe, act.bsy, act.rv, act.cnt,
                     exp.rdy, exp.ld, exp.it, exp.oe, exp.bsy, exp.rv, exp.cnt);
        end
    endtask

    // One clock cycle: drive, check before the edge, then advance the model past the edge.
    task automatic cycle(input bit rv, input bit rr, input bit ab, input bit use_model,
                         input obs_t texp, input string name);
        req_valid = rv;
        res_ready = rr;
`ifdef SEQ_ABORT_EN
        abort_drv = ab;
`endif
        @(negedge clock);
        check(name, use_model ? model_exp(rv, ab) : texp);
        @(posedge clock);
        #1;
        model_update(rv, rr, ab);
    endtask

    task automatic mcycle(input bit rv, input bit rr, input bit ab, input string name);
        obs_t dummy;
        dummy = '0;
        cycle(rv, rr, ab, 1'b1, dummy, name);
    endtask

    vec_t tab[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t e;
        obs_t idle_exp;
        bit   ab;

        tab[0]  = '{1'b0, 1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0};
        tab[1]  = '{1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0};
        tab[2]  = '{1'b0, 1'b0, 27, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  0, 1};
        tab[3]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 27, 0};
        tab[4]  = '{1'b0, 1'b0,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  0, 0};
        tab[5]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  0, 0};
        tab[6]  = '{1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0};
        tab[7]  = '{1'b1, 1'b1, 27, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  0, 1};
        tab[8]  = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 27, 0};
        tab[9]  = '{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  0, 0};
        tab[10] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  0, 0};
        tab[11] = '{1'b0, 1'b0,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 0};

        idle_exp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CW'(0)};

        reset     = 1'b1;
        req_valid = 1'b0;
        res_ready = 1'b0;
`ifdef SEQ_ABORT_EN
        abort_drv = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("reset_asserted", idle_exp);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        age = -1;

        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < tab[i].reps; r++) begin
                e = '{tab[i].e_rdy, tab[i].e_ld, tab[i].e_it, tab[i].e_oe, tab[i].e_bsy,
                      tab[i].e_resv, CW'(tab[i].cnt0 + r * tab[i].cnt_step)};
                cycle(tab[i].rv, tab[i].rr, 1'b0, 1'b0, e, $sformatf("table[%0d].%0d", i, r));
            end
        end

        // Reset asserted mid-operation at iter_cnt=13.
        mcycle(1'b1, 1'b0, 1'b0, "mid_reset_accept");
        for (int k = 0; k < 13; k++) mcycle(1'b0, 1'b0, 1'b0, "mid_reset_iter");
        #2;
        reset = 1'b1;
        #1;
        age = -1;
        check("mid_reset_async", idle_exp);
        @(negedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        mcycle(1'b1, 1'b0, 1'b0, "post_reset_accept");
        for (int k = 0; k < ITERS; k++) mcycle(1'b0, 1'b0, 1'b0, "post_reset_iter");
        mcycle(1'b0, 1'b1, 1'b0, "post_reset_take");
        mcycle(1'b0, 1'b0, 1'b0, "post_reset_idle");

`ifdef SEQ_ABORT_EN
        // Abort at the final iteration, abort alongside accept, and abort while holding.
        mcycle(1'b1, 1'b0, 1'b0, "abort_accept");
        for (int k = 0; k < ITERS - 1; k++) mcycle(1'b0, 1'b0, 1'b0, "abort_iter");
        mcycle(1'b0, 1'b0, 1'b1, "abort_last");
        for (int k = 0; k < 3; k++) mcycle(1'b0, 1'b0, 1'b0, "abort_no_result");
        mcycle(1'b1, 1'b0, 1'b1, "abort_in_idle_accepts");
        for (int k = 0; k < ITERS; k++) mcycle(1'b0, 1'b0, 1'b0, "abort_iter2");
        mcycle(1'b0, 1'b0, 1'b0, "abort_hold");
        mcycle(1'b0, 1'b1, 1'b1, "abort_in_hold");
        mcycle(1'b0, 1'b0, 1'b0, "abort_hold_idle");
`endif

        for (int k = 0; k < 800; k++) begin
            ab = 1'b0;
`ifdef SEQ_ABORT_EN
            ab = ($urandom_range(0, 19) == 0);
`endif
            mcycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, ab, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
